// File: rtl/core_config_pkg.sv
// Core-wide configuration constants shared by the execution and commit stages.
// Only the widths needed by the commit path live here.
package core_config_pkg;

  parameter int XLEN       = 32;
  parameter int REG_ADDR_W = 5;

endpackage

// File: rtl/alu_commit_arbiter.sv
// Round-robin commit stage: collects finished results and writes one per cycle.
// Optional COMMIT_PERF_EN adds perf_commits / perf_stalls counters.
module alu_commit_arbiter
  import core_config_pkg::*;
#(
  parameter int NUM_UNITS  = 2,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS-1:0]            req,
  input  logic [NUM_UNITS-1:0]            valid,
  input  logic [NUM_UNITS-1:0]            err,
  input  logic [NUM_UNITS*XLEN-1:0]       res,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] rd,
  output logic [NUM_UNITS-1:0]            clear,
  output logic                            rf_we,
  output logic [REG_ADDR_W-1:0]           rf_waddr,
  output logic [XLEN-1:0]                 rf_wdata,
  output logic                            exc_valid,
  output logic [2:0]                      exc_unit,
  input  logic                            exc_ack,
`ifdef COMMIT_PERF_EN
  output logic [31:0]                     perf_commits,
  output logic [31:0]                     perf_stalls,
`endif
  output logic                            stall
);

  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NUM_UNITS-1:0]    clear_q, clear_d;
  logic                    we_q, we_d;
  logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;
  logic                    excv_q, excv_d;
  logic [2:0]              excu_q, excu_d;

  logic [NUM_UNITS-1:0]    elig;
  logic [NUM_UNITS-1:0]    cand;
  logic [2*NUM_UNITS-1:0]  dbl;
  logic [NUM_UNITS-1:0]    rot;
  logic                    gnt_vld;
  logic [PW-1:0]           gnt_off;
  logic [PW:0]             gnt_sum;
  logic [PW-1:0]           gnt_idx;
  logic                    g_err;
  logic [XLEN-1:0]         g_res;
  logic [REG_ADDR_W-1:0]   g_rd;

  assign elig = req & valid;

  // The unit granted last cycle still shows req before it sees clear.
  assign cand = (state_q == RUN) ? (elig & ~clear_q) : '0;

  always_comb begin
    dbl     = {cand, cand} >> ptr_q;
    rot     = dbl[NUM_UNITS-1:0];
    gnt_vld = 1'b0;
    gnt_off = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!gnt_vld && rot[i]) begin
        gnt_vld = 1'b1;
        gnt_off = PW'(i);
      end
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= (PW+1)'(NUM_UNITS)) begin
      gnt_sum = gnt_sum - (PW+1)'(NUM_UNITS);
    end
    gnt_idx = gnt_sum[PW-1:0];
  end

  always_comb begin
    g_err = 1'b0;
    g_res = '0;
    g_rd  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (gnt_idx == PW'(i)) begin
        g_err = err[i];
        g_res = res[i*XLEN +: XLEN];
        g_rd  = rd[i*REG_ADDR_W +: REG_ADDR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clear_d = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    excv_d  = excv_q;
    excu_d  = excu_q;
    unique case (state_q)
      RUN: begin
        if (gnt_vld) begin
          clear_d = NUM_UNITS'(1) << gnt_idx;
          if (gnt_idx == PW'(NUM_UNITS-1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_idx + 1'b1;
          end
          if (g_err) begin
            state_d = HALT;
            excv_d  = 1'b1;
            excu_d  = 3'(gnt_idx);
          end else if (g_rd != '0) begin
            we_d    = 1'b1;
            waddr_d = g_rd;
            wdata_d = g_res;
          end
        end
      end
      HALT: begin
        if (exc_ack) begin
          state_d = RUN;
          excv_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ptr_q   <= '0;
      clear_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      excv_q  <= 1'b0;
      excu_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      clear_q <= clear_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      excv_q  <= excv_d;
      excu_q  <= excu_d;
    end
  end

  assign clear     = clear_q;
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign exc_valid = excv_q;
  assign exc_unit  = excu_q;
  assign stall     = (state_q == HALT);

`ifdef COMMIT_PERF_EN
  logic [31:0] pc_q;
  logic [31:0] ps_q;

  // Commits count off the clear pulse itself; stalls off the lost cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      ps_q <= '0;
    end else begin
      if (|clear_q) begin
        pc_q <= pc_q + 32'd1;
      end
      if ((|elig) && !gnt_vld) begin
        ps_q <= ps_q + 32'd1;
      end
    end
  end

  assign perf_commits = pc_q;
  assign perf_stalls  = ps_q;
`endif

endmodule

// File: doc/alu_commit_arbiter.md
Name: alu_commit_arbiter

Overview:
- Commit stage directly downstream of the ALUs and other execution units.
- Collects finished results over the req/clear handshake from NUM_UNITS producers using round-robin arbitration.
- Commits at most one result per cycle to the register-file write port and acknowledges the winner with a one-cycle clear pulse.
- Traps producer errors: raises an exception toward the control unit and halts commits until acknowledged.

Parameters:
- NUM_UNITS, 2, number of producer units (1..8); index 0 is the ALU.
- XLEN, core_config_pkg::XLEN, data width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W, register address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_UNITS  per-unit commit request.
- valid  in  NUM_UNITS  per-unit result-valid qualifier.
- err  in  NUM_UNITS  per-unit error flag (a producer's o_error).
- res  in  NUM_UNITS*XLEN  packed results; unit i occupies bits [i*XLEN +: XLEN].
- rd  in  NUM_UNITS*REG_ADDR_W  packed destination registers; same packing as res.
- clear  out  NUM_UNITS  one-hot acknowledge pulse.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  XLEN  write data.
- exc_valid  out  1  exception pending (level).
- exc_unit  out  3  index of the faulting unit.
- exc_ack  in  1  control unit has taken the exception.
- stall  out  1  high while in HALT.

Behaviour:
- Reset values: all outputs 0; round-robin pointer 0; state RUN.
- A unit is eligible when req[i] && valid[i]; req without valid is ignored.
- Producer contract: hold res/rd/err stable while req is high; drop req the cycle after clear.
- Arbitration: in RUN, the grant goes to the first eligible unit starting at the pointer and searching upward with wrap. After a grant, pointer = granted index + 1, wrapping to 0 after NUM_UNITS-1. With no eligible unit, the pointer is held.
- Grant cycle T, all outputs registered:
  - clear[g] = 1 at T+1 for exactly one cycle.
  - In the same cycle T+1, rf_we / rf_waddr / rf_wdata present the result.
  - Latency from request to write is 1 cycle.
- A unit that still shows req at T+1 (before seeing clear) is not re-granted in T+1. The block masks the unit granted in the previous cycle.
- rd == 0: clear is still issued, but rf_we stays 0 (x0 is hardwired).
- rf_waddr and rf_wdata hold their last values while rf_we = 0.
- Error grant (err[g] = 1):
  - clear[g] is pulsed; no register write.
  - exc_valid = 1 and exc_unit = g at T+1.
  - State goes to HALT.
- HALT:
  - No grants; stall = 1; exc_valid held.
  - exc_ack moves the state to RUN at the next edge and clears exc_valid and stall. Arbitration resumes in the following cycle.
- exc_ack in RUN is ignored.
- rst asserted mid-operation: all state clears at the next edge regardless of pending requests. Any in-flight clear or rf_we is dropped.
- NUM_UNITS = 1: the pointer stays at 0. The single unit can commit at most every 2 cycles because of the grant mask.

Optional Feature:
- Macro COMMIT_PERF_EN.
- When defined, two output ports are added:
  - perf_commits (32 bits): increments on every clear pulse, error grants included.
  - perf_stalls (32 bits): increments on every cycle where any unit is eligible but none is granted (HALT or grant mask).
- Both counters wrap at 2^32, reset to 0, and are visible one cycle after the event.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single commit: unit0 req/valid, rd=5, res=0xDEADBEEF at T -> clear=2'b01, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at T+1 only.
- Fairness: units 0 and 1 request continuously for 4 grants, starting from pointer 0 -> grant order 0,1,0,1; each clear pulse is one cycle.
- x0 write: unit1 rd=0, res=0x12345678 -> clear=2'b10, rf_we stays 0, rf_waddr/rf_wdata unchanged.
- Error trap: unit1 err=1 -> clear=2'b10, no write, exc_valid=1, exc_unit=1, stall=1. Unit0 requesting during HALT is not granted. exc_ack for 1 cycle -> unit0 cleared 2 cycles after ack.
- Reset mid-operation: rst high while unit0 has just been granted -> next cycle clear=0, rf_we=0, exc_valid=0, and first post-reset grant goes to unit0 (pointer 0).
- With COMMIT_PERF_EN: 3 commits plus 2 HALT cycles with a pending request -> perf_commits=3, perf_stalls=2.
